// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: validates 4-byte UART command frames (SOF, CMD, ARG, CHK)
// and turns them into Pong control outputs (start pulse, pause level, paddle
// requests). Optional macro LEGACY_ANY_BYTE_START_EN makes any non-SOF byte
// received in IDLE pulse o_Game_Start.
module uart_cmd_decoder #(
  parameter int unsigned HOLD_CLKS    = 25000,
  parameter int unsigned TIMEOUT_CLKS = 2500000,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Game_Start,
  output logic       o_Pause,
  output logic       o_Paddle_Up_P1,
  output logic       o_Paddle_Dn_P1,
  output logic       o_Paddle_Up_P2,
  output logic       o_Paddle_Dn_P2,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Err_Count
);

  localparam int HW = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CLKS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ARG  = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_s;
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic          start_q, start_d, valid_q, valid_d, pause_q, pause_d;
  logic          up1_q, up1_d, dn1_q, dn1_d, up2_q, up2_d, dn2_q, dn2_d;
  logic          inc_err_s;

  // Reset synchronizer: assertion reaches the core immediately, release is clocked.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_s = rst_sync_q[1];

  // Next-state logic: frame FSM, inter-byte timeout, command actions, hold timers.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    start_d   = 1'b0;
    valid_d   = 1'b0;
    pause_d   = pause_q;
    up1_d     = up1_q;
    dn1_d     = dn1_q;
    up2_d     = up2_q;
    dn2_d     = dn2_q;
    hold1_d   = hold1_q;
    hold2_d   = hold2_q;
    inc_err_s = 1'b0;

    // Paddle requests count down and drop once their hold window is spent.
    if (up1_q || dn1_q) begin
      if (hold1_q == HW'(0)) begin
        up1_d = 1'b0;
        dn1_d = 1'b0;
      end else begin
        hold1_d = hold1_q - HW'(1);
      end
    end else begin
      hold1_d = hold1_q;
    end
    if (up2_q || dn2_q) begin
      if (hold2_q == HW'(0)) begin
        up2_d = 1'b0;
        dn2_d = 1'b0;
      end else begin
        hold2_d = hold2_q - HW'(1);
      end
    end else begin
      hold2_d = hold2_q;
    end

    if (state_q == ST_IDLE) begin
      tmo_d = TW'(0);
      if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
        state_d = ST_CMD;
      end else begin
`ifdef LEGACY_ANY_BYTE_START_EN
        start_d = i_Rx_DV;
`else
        start_d = 1'b0;
`endif
      end
    end else if (!i_Rx_DV) begin
      // A byte arriving on the expiry cycle takes the other branch, so it wins.
      if (tmo_q == TMO_LAST) begin
        state_d   = ST_IDLE;
        tmo_d     = TW'(0);
        inc_err_s = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = TW'(0);
      case (state_q)
        ST_CMD: begin
          cmd_d   = i_Rx_Byte;
          state_d = ST_ARG;
        end
        ST_ARG: begin
          arg_d   = i_Rx_Byte;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (i_Rx_Byte != (cmd_q ^ arg_q)) begin
            inc_err_s = 1'b1;
          end else begin
            case (cmd_q)
              8'h01: begin
                start_d = 1'b1;
                valid_d = 1'b1;
              end
              8'h02: begin
                pause_d = arg_q[0];
                valid_d = 1'b1;
              end
              8'h10: begin
                // Up and down together is contradictory and resolves to neither.
                up1_d   = arg_q[0] & ~arg_q[1];
                dn1_d   = arg_q[1] & ~arg_q[0];
                hold1_d = HOLD_LOAD;
                valid_d = 1'b1;
              end
              8'h11: begin
                up2_d   = arg_q[0] & ~arg_q[1];
                dn2_d   = arg_q[1] & ~arg_q[0];
                hold2_d = HOLD_LOAD;
                valid_d = 1'b1;
              end
              default: begin
                inc_err_s = 1'b1;
              end
            endcase
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (inc_err_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers; a reset anywhere in a frame discards it.
  always_ff @(posedge i_Clk or posedge rst_s) begin
    if (rst_s) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'h00;
      arg_q   <= 8'h00;
      tmo_q   <= TW'(0);
      err_q   <= 8'h00;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      pause_q <= 1'b0;
      up1_q   <= 1'b0;
      dn1_q   <= 1'b0;
      up2_q   <= 1'b0;
      dn2_q   <= 1'b0;
      hold1_q <= HW'(0);
      hold2_q <= HW'(0);
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= start_d;
      valid_q <= valid_d;
      pause_q <= pause_d;
      up1_q   <= up1_d;
      dn1_q   <= dn1_d;
      up2_q   <= up2_d;
      dn2_q   <= dn2_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
    end
  end

  assign o_Game_Start   = start_q;
  assign o_Pause        = pause_q;
  assign o_Paddle_Up_P1 = up1_q;
  assign o_Paddle_Dn_P1 = dn1_q;
  assign o_Paddle_Up_P2 = up2_q;
  assign o_Paddle_Dn_P2 = dn2_q;
  assign o_Cmd_Valid    = valid_q;
  assign o_Err_Count    = err_q;

endmodule
